flag_branch_unit: RTL

- Consumer end of the ALU flag interface.
- Holds the architectural flag register {N,V,Z}, written from ALU flag outputs according to the ALU opcode.
- Resolves conditional branches against those flags, including a wait state when flags are still in flight.
- Sits between the execute stage (ALU) and the fetch stage, and drives the PC redirect.

---
 rtl/flag_branch_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Consumer end of the ALU flag interface. Holds the
//               architectural {N,V,Z} flag register, updates it from the ALU
//               according to an opcode mask, and resolves conditional
//               branches against it. When a flag-setting instruction is still
//               in flight, the branch waits (bounded by WAIT_MAX cycles)
//               before resolving. Drives a one-cycle PC redirect pulse.
//
// Parameters  : WAIT_MAX  1..255, cycles in the wait state before a forced
//                         resolve
//               PC_W      PC / target width
//
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               alu_flags, alu_op,    ALU flag result, opcode, valid strobe
//               flags_we
//               flags_pending         flag producer issued but not yet at ALU
//               br_valid, br_ready    branch request handshake
//               br_cond, br_target,   condition code, taken PC, not-taken PC
//               br_fallthru
//               redirect_valid/taken/pc  resolved branch outcome
//               flags_q               current flag register {N,V,Z}
//               wait_timeout          pulse on a forced resolve
//
// Optional    : `define BRANCH_STATS_EN adds stat_clr (in) and the
//               stat_resolved / stat_taken 16-bit counters (out).
//
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
    parameter int WAIT_MAX = 8,
    parameter int PC_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      alu_flags,
    input  logic [3:0]      alu_op,
    input  logic            flags_we,
    input  logic            flags_pending,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] br_fallthru,
    output logic            redirect_valid,
    output logic            redirect_taken,
    output logic [PC_W-1:0] redirect_pc,
    output logic [2:0]      flags_q,
    output logic            wait_timeout
`ifdef BRANCH_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [15:0]     stat_resolved,
    output logic [15:0]     stat_taken
`endif
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WAIT_FLAGS = 2'd1;
    localparam logic [1:0] c_RESOLVE    = 2'd2;

    localparam logic [7:0] c_WAIT_MAX = 8'(WAIT_MAX);

    logic [1:0]      state_q, state_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [2:0]      cond_q, cond_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [PC_W-1:0] fallthru_q, fallthru_d;
    logic            taken_q;
    logic [PC_W-1:0] pc_q;
    logic [2:0]      flags_d;

    logic            w_wr_all;
    logic            w_wr_z;
    logic            w_go;
    logic            w_taken;
    logic [2:0]      w_sel_cond;
    logic [PC_W-1:0] w_sel_target;
    logic [PC_W-1:0] w_sel_fallthru;

    // Condition evaluation on f = {N,V,Z}
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (cond)
            3'b000:  return !z;
            3'b001:  return z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || !n;
            3'b101:  return n || z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    // Masked flag merge. flags_d doubles as the forwarded "effective" flags:
    // it equals flags_q whenever nothing is written this cycle.
    always_comb begin
        w_wr_all = flags_we && ((alu_op == 4'b0000) || (alu_op == 4'b0010));
        w_wr_z   = flags_we && (alu_op >= 4'b0011) && (alu_op <= 4'b0111);
        flags_d  = flags_q;
        if (w_wr_all) begin
            flags_d = alu_flags;
        end else if (w_wr_z) begin
            flags_d[0] = alu_flags[0];
        end
    end

    // Branch FSM next-state logic
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        cond_d         = cond_q;
        target_d       = target_q;
        fallthru_d     = fallthru_q;
        w_go           = 1'b0;
        w_sel_cond     = cond_q;
        w_sel_target   = target_q;
        w_sel_fallthru = fallthru_q;
        wait_timeout   = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (br_valid) begin
                    cond_d     = br_cond;
                    target_d   = br_target;
                    fallthru_d = br_fallthru;
                    // Pending dominates: a same-cycle flag write is not
                    // trusted to be the producer the branch depends on.
                    if (flags_pending) begin
                        state_d = c_WAIT_FLAGS;
                        wcnt_d  = 8'd0;
                    end else begin
                        w_go           = 1'b1;
                        w_sel_cond     = br_cond;
                        w_sel_target   = br_target;
                        w_sel_fallthru = br_fallthru;
                    end
                end
            end
            c_WAIT_FLAGS: begin
                if (flags_we || !flags_pending) begin
                    w_go = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (wcnt_d == c_WAIT_MAX) begin
                        w_go         = 1'b1;
                        wait_timeout = 1'b1;
                    end
                end
            end
            c_RESOLVE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (w_go) begin
            state_d = c_RESOLVE;
        end
    end

    // Evaluated on flags_d: forwarded when flags_we=1, flags_q otherwise
    assign w_taken = cond_met(w_sel_cond, flags_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            wcnt_q     <= 8'd0;
            cond_q     <= 3'd0;
            target_q   <= '0;
            fallthru_q <= '0;
            taken_q    <= 1'b0;
            pc_q       <= '0;
            flags_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            cond_q     <= cond_d;
            target_q   <= target_d;
            fallthru_q <= fallthru_d;
            flags_q    <= flags_d;
            // Outcome registers only move on a resolve, so they hold
            // their last value while redirect_valid is low.
            if (w_go) begin
                taken_q <= w_taken;
                pc_q    <= w_taken ? w_sel_target : w_sel_fallthru;
            end
        end
    end

    // rst_n is folded in so the unit never advertises readiness in reset
    assign br_ready       = (state_q == c_IDLE) && rst_n;
    assign redirect_valid = (state_q == c_RESOLVE);
    assign redirect_taken = taken_q;
    assign redirect_pc    = pc_q;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= 16'd0;
            stat_taken    <= 16'd0;
        end else if (stat_clr) begin
            stat_resolved <= 16'd0;
            stat_taken    <= 16'd0;
        end else if (state_q == c_RESOLVE) begin
            stat_resolved <= stat_resolved + 16'd1;
            if (taken_q) begin
                stat_taken <= stat_taken + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
